// File: rtl/mem2_load_resp.sv
// MEM2 load-response stage: waits for the DCache read word, aligns and
// extends it, stalls the MEM2 register while a response is outstanding,
// discards responses that belong to flushed loads and registers the WB record.
module mem2_load_resp #(
  parameter int unsigned RESP_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem2_valid,
  input  logic        mem2_is_load,
  input  logic        mem2_exc,
  input  logic [31:0] mem2_aluout,
  input  logic [31:0] mem2_pc,
  input  logic [4:0]  mem2_dst,
  input  logic        mem2_regwr,
  input  logic [1:0]  mem2_load_size,
  input  logic        mem2_load_sign,
  input  logic        flush,
  input  logic        dc_resp_valid,
  input  logic [31:0] dc_rdata,
  output logic        mem2_stall,
  output logic        wb_valid,
  output logic [31:0] wb_pc,
  output logic [4:0]  wb_dst,
  output logic        wb_regwr,
  output logic [31:0] wb_data,
  output logic        err_timeout
);

  // IDLE: no response owed. WAIT: the held load owns the next response.
  // DRAIN: a flushed load's response is still in flight and must be eaten.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic        err_q, err_d;

  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_pc_q, wb_pc_d;
  logic [4:0]  wb_dst_q, wb_dst_d;
  logic        wb_regwr_q, wb_regwr_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic        load_live;   // live load that expects a DCache response
  logic        need;        // same, and not being killed this cycle
  logic        stall;
  logic [31:0] wait_cnt_inc;

  logic [7:0]  rd_byte [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  assign load_live = mem2_valid & mem2_is_load & ~mem2_exc;
  assign need      = load_live & ~flush;

  // Byte lanes of the returned word, indexed by the low address bits.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_byte[gi] = dc_rdata[8*gi +: 8];
  end

  // Load alignment and sign/zero extension; size 3 behaves as a word.
  always_comb begin
    byte_sel = rd_byte[mem2_aluout[1:0]];
    // a[0] is deliberately ignored for halves; misaligned halves trap upstream.
    half_sel = mem2_aluout[1] ? dc_rdata[31:16] : dc_rdata[15:0];
    case (mem2_load_size)
      2'd0:    load_data = {{24{mem2_load_sign & byte_sel[7]}}, byte_sel};
      2'd1:    load_data = {{16{mem2_load_sign & half_sel[15]}}, half_sel};
      default: load_data = dc_rdata;
    endcase
  end

  // Next-state and stall decode for the response-tracking FSM.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A same-cycle response completes the load without stalling.
        if (need && !dc_resp_valid) begin
          stall   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dc_resp_valid) begin
          // With a coincident flush the response is simply dropped.
          state_d = ST_IDLE;
        end else if (flush) begin
          // Killed while the read is in flight: its response comes later.
          state_d = ST_DRAIN;
        end else begin
          stall = 1'b1;
        end
      end
      ST_DRAIN: begin
        // A new load cannot be matched to a response until the stale one is gone.
        stall = load_live;
        if (dc_resp_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Watchdog: count consecutive WAIT cycles, raise a sticky flag at the limit.
  always_comb begin
    wait_cnt_inc = (wait_cnt_q == 32'hFFFF_FFFF) ? wait_cnt_q : wait_cnt_q + 32'd1;
    wait_cnt_d   = 32'd0;
    err_d        = err_q;
    if (state_q == ST_WAIT) begin
      if (RESP_TIMEOUT != 0 && wait_cnt_inc == 32'(RESP_TIMEOUT)) begin
        err_d = 1'b1;
      end
      if (state_d == ST_WAIT) begin
        wait_cnt_d = wait_cnt_inc;
      end
    end
  end

  // WB record: capture on any non-stalled, non-flushed instruction, else bubble.
  always_comb begin
    wb_valid_d = mem2_valid & ~flush & ~stall;
    wb_pc_d    = wb_pc_q;
    wb_dst_d   = wb_dst_q;
    wb_regwr_d = 1'b0;
    wb_data_d  = wb_data_q;
    if (wb_valid_d) begin
      wb_pc_d    = mem2_pc;
      wb_dst_d   = mem2_dst;
      wb_regwr_d = mem2_regwr;
      // Excepted loads and non-loads carry the ALU result instead of memory data.
      wb_data_d  = load_live ? load_data : mem2_aluout;
    end
  end

  // State, watchdog and WB registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 32'd0;
      err_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_pc_q    <= 32'd0;
      wb_dst_q   <= 5'd0;
      wb_regwr_q <= 1'b0;
      wb_data_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      wb_valid_q <= wb_valid_d;
      wb_pc_q    <= wb_pc_d;
      wb_dst_q   <= wb_dst_d;
      wb_regwr_q <= wb_regwr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign mem2_stall  = stall;
  assign wb_valid    = wb_valid_q;
  assign wb_pc       = wb_pc_q;
  assign wb_dst      = wb_dst_q;
  assign wb_regwr    = wb_regwr_q;
  assign wb_data     = wb_data_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_mem2_load_resp.sv
// Testbench for mem2_load_resp: alignment table, hand-written corner-case
// sequences and randomized traffic checked against a behavioural model.
module tb_mem2_load_resp;
  localparam int unsigned TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem2_valid, mem2_is_load, mem2_exc, mem2_regwr, mem2_load_sign;
  logic [31:0] mem2_aluout, mem2_pc, dc_rdata;
  logic [4:0]  mem2_dst;
  logic [1:0]  mem2_load_size;
  logic        flush, dc_resp_valid;
  logic        mem2_stall, wb_valid, wb_regwr, err_timeout;
  logic [31:0] wb_pc, wb_data;
  logic [4:0]  wb_dst;

  mem2_load_resp #(.RESP_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .mem2_valid(mem2_valid), .mem2_is_load(mem2_is_load), .mem2_exc(mem2_exc),
    .mem2_aluout(mem2_aluout), .mem2_pc(mem2_pc), .mem2_dst(mem2_dst),
    .mem2_regwr(mem2_regwr), .mem2_load_size(mem2_load_size),
    .mem2_load_sign(mem2_load_sign), .flush(flush),
    .dc_resp_valid(dc_resp_valid), .dc_rdata(dc_rdata),
    .mem2_stall(mem2_stall), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_dst(wb_dst), .wb_regwr(wb_regwr), .wb_data(wb_data),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic stall_seen;

  // Behavioural model: "a response is owed to the held load" and
  // "a response for a killed load is still coming", plus the WB record.
  bit          m_pending, m_stale, m_err, m_stall;
  int unsigned m_wait;
  bit          m_wbv, m_wbrw;
  logic [31:0] m_pc, m_data;
  logic [4:0]  m_dst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_align(logic [1:0] sz, bit sg, logic [1:0] a, logic [31:0] rd);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * a)) & 32'hFF;
      if (sg && v[7]) v = v - 32'h100;
    end else if (sz == 2'd1) begin
      v = (rd >> (a[1] ? 16 : 0)) & 32'hFFFF;
      if (sg && v[15]) v = v - 32'h10000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_pending = 0; m_stale = 0; m_err = 0; m_wait = 0; m_stall = 0;
    m_wbv = 0; m_wbrw = 0; m_pc = 0; m_data = 0; m_dst = 0;
  endtask

  task automatic drive_idle();
    mem2_valid = 0; mem2_is_load = 0; mem2_exc = 0; mem2_aluout = 0; mem2_pc = 0;
    mem2_dst = 0; mem2_regwr = 0; mem2_load_size = 0; mem2_load_sign = 0;
    flush = 0; dc_resp_valid = 0; dc_rdata = 0;
  endtask

  // Called at a negedge: asynchronous reset, outputs checked while rst is high.
  task automatic do_reset();
    drive_idle();
    rst = 1;
    #1;
    model_reset();
    check("rst_stall", mem2_stall, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_regwr", wb_regwr, 0);
    check("rst_wb_pc", wb_pc, 0);
    check("rst_wb_dst", wb_dst, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_err", err_timeout, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  // One clock cycle: drive at negedge, check stall, step model, check WB after the edge.
  task automatic cyc(input bit v, input bit ld, input bit ex, input logic [31:0] addr,
                     input logic [31:0] pc, input logic [4:0] dst, input bit rw,
                     input logic [1:0] sz, input bit sg, input bit fl, input bit rv,
                     input logic [31:0] rd);
    bit need;
    mem2_valid = v; mem2_is_load = ld; mem2_exc = ex; mem2_aluout = addr; mem2_pc = pc;
    mem2_dst = dst; mem2_regwr = rw; mem2_load_size = sz; mem2_load_sign = sg;
    flush = fl; dc_resp_valid = rv; dc_rdata = rd;
    #1;
    need = v && ld && !ex && !fl;
    m_stall = 0;
    if (m_stale) begin
      m_stall = v && ld && !ex;
      if (rv) m_stale = 0;
    end else if (m_pending) begin
      m_wait++;
      if (TIMEOUT != 0 && m_wait >= TIMEOUT) m_err = 1;
      if (rv) m_pending = 0;
      else if (fl) begin m_pending = 0; m_stale = 1; end
      else m_stall = 1;
    end else if (need && !rv) begin
      m_stall = 1;
      m_pending = 1;
    end
    if (!m_pending) m_wait = 0;
    m_wbv = v && !fl && !m_stall;
    if (m_wbv) begin
      m_pc = pc; m_dst = dst; m_wbrw = rw;
      m_data = (ld && !ex) ? ref_align(sz, sg, addr[1:0], rd) : addr;
    end else begin
      m_wbrw = 0;
    end
    check("stall", mem2_stall, m_stall);
    stall_seen = mem2_stall;
    @(posedge clk);
    #1;
    check("wb_valid", wb_valid, m_wbv);
    check("wb_regwr", wb_regwr, m_wbrw);
    check("wb_pc", wb_pc, m_pc);
    check("wb_dst", wb_dst, m_dst);
    check("wb_data", wb_data, m_data);
    check("err_timeout", err_timeout, m_err);
    $display("[TB] v=%0b ld=%0b ex=%0b fl=%0b rv=%0b addr=%h stall=%0b wb_valid=%0b wb_data=%h err=%0b",
             v, ld, ex, fl, rv, addr, stall_seen, wb_valid, wb_data, err_timeout);
    @(negedge clk);
  endtask

  typedef struct {
    bit          ld;
    bit          ex;
    bit          rv;
    logic [1:0]  sz;
    bit          sg;
    logic [31:0] addr;
    logic [31:0] rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  initial begin
    bit          hold;
    bit          r_v, r_ld, r_ex, r_rw, r_sg;
    logic [31:0] r_addr, r_pc;
    logic [4:0]  r_dst;
    logic [1:0]  r_sz;

    vecs[0]  = '{1, 0, 1, 2'd2, 0, 32'h0000_1000, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1]  = '{1, 0, 1, 2'd0, 1, 32'h0000_1003, 32'h80FFFFFF, 32'hFFFFFF80};
    vecs[2]  = '{1, 0, 1, 2'd1, 0, 32'h0000_2002, 32'hBEEF1234, 32'h0000BEEF};
    vecs[3]  = '{1, 0, 1, 2'd1, 1, 32'h0000_2000, 32'hBEEF1234, 32'h00001234};
    vecs[4]  = '{1, 0, 1, 2'd1, 1, 32'h0000_2002, 32'hBEEF1234, 32'hFFFFBEEF};
    vecs[5]  = '{1, 0, 1, 2'd0, 0, 32'h0000_1001, 32'h12345678, 32'h00000056};
    vecs[6]  = '{1, 0, 1, 2'd0, 1, 32'h0000_1002, 32'h12F45678, 32'hFFFFFFF4};
    vecs[7]  = '{1, 0, 1, 2'd0, 1, 32'h0000_1000, 32'h12345678, 32'h00000078};
    vecs[8]  = '{1, 0, 1, 2'd3, 1, 32'h0000_1002, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[9]  = '{1, 0, 1, 2'd1, 0, 32'h0000_2003, 32'hA1B2C3D4, 32'h0000A1B2};
    vecs[10] = '{1, 0, 1, 2'd1, 1, 32'h0000_2001, 32'hA1B28001, 32'hFFFF8001};
    vecs[11] = '{0, 0, 0, 2'd2, 0, 32'h1234_5678, 32'h0, 32'h12345678};
    vecs[12] = '{1, 1, 0, 2'd2, 0, 32'h0000_BAD0, 32'h0, 32'h0000BAD0};
    vecs[13] = '{0, 0, 1, 2'd0, 1, 32'h0000_0077, 32'hFFFFFFFF, 32'h00000077};

    drive_idle();
    rst = 1;
    @(negedge clk);
    do_reset();

    // Alignment / pass-through table, every row completes in one cycle.
    for (int i = 0; i < 14; i++) begin
      cyc(1, vecs[i].ld, vecs[i].ex, vecs[i].addr, 32'h400 + 32'(i * 4), 5'(i + 1), 1,
          vecs[i].sz, vecs[i].sg, 0, vecs[i].rv, vecs[i].rd);
      check($sformatf("tbl%0d_stall", i), stall_seen, 0);
      check($sformatf("tbl%0d_valid", i), wb_valid, 1);
      check($sformatf("tbl%0d_data", i), wb_data, vecs[i].exp);
    end

    // lb after a 3-cycle response delay: stall exactly 3 cycles, one WB record.
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 32'h1003, 32'h500, 5'd7, 1, 2'd0, 1, 0, 0, 32'h0);
      check("lb_wait_stall", stall_seen, 1);
      check("lb_wait_bubble", wb_valid, 0);
    end
    cyc(1, 1, 0, 32'h1003, 32'h500, 5'd7, 1, 2'd0, 1, 0, 1, 32'h80FFFFFF);
    check("lb_resp_stall", stall_seen, 0);
    check("lb_resp_valid", wb_valid, 1);
    check("lb_resp_data", wb_data, 32'hFFFFFF80);
    cyc(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 2'd0, 0, 0, 0, 32'h0);
    check("lb_once", wb_valid, 0);

    // Flushed load's stale response must not reach WB.
    cyc(1, 1, 0, 32'h3000, 32'h600, 5'd3, 1, 2'd2, 0, 0, 0, 32'h0);
    check("stale_c1_stall", stall_seen, 1);
    cyc(1, 1, 0, 32'h3000, 32'h600, 5'd3, 1, 2'd2, 0, 1, 0, 32'h0);
    check("stale_c2_stall", stall_seen, 0);
    check("stale_c2_bubble", wb_valid, 0);
    cyc(1, 1, 0, 32'h3004, 32'h604, 5'd4, 1, 2'd2, 0, 0, 0, 32'h0);
    check("stale_c3_stall", stall_seen, 1);
    cyc(1, 1, 0, 32'h3004, 32'h604, 5'd4, 1, 2'd2, 0, 0, 1, 32'h11111111);
    check("stale_c4_stall", stall_seen, 1);
    check("stale_c4_bubble", wb_valid, 0);
    cyc(1, 1, 0, 32'h3004, 32'h604, 5'd4, 1, 2'd2, 0, 0, 0, 32'h0);
    check("stale_c5_stall", stall_seen, 1);
    cyc(1, 1, 0, 32'h3004, 32'h604, 5'd4, 1, 2'd2, 0, 0, 1, 32'h22222222);
    check("stale_c6_valid", wb_valid, 1);
    check("stale_c6_data", wb_data, 32'h22222222);

    // Flush coincident with the response in WAIT: dropped, back to IDLE.
    cyc(1, 1, 0, 32'h3100, 32'h700, 5'd5, 1, 2'd2, 0, 0, 0, 32'h0);
    cyc(1, 1, 0, 32'h3100, 32'h700, 5'd5, 1, 2'd2, 0, 1, 1, 32'h33333333);
    check("flresp_stall", stall_seen, 0);
    check("flresp_bubble", wb_valid, 0);
    cyc(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 2'd0, 0, 0, 0, 32'h0);
    check("flresp_idle_stall", stall_seen, 0);

    // Watchdog: flag rises after the 4th WAIT cycle, sticks, load still completes.
    cyc(1, 1, 0, 32'h4000, 32'h800, 5'd9, 1, 2'd2, 0, 0, 0, 32'h0);
    check("wd_issue_err", err_timeout, 0);
    for (int i = 1; i <= 6; i++) begin
      cyc(1, 1, 0, 32'h4000, 32'h800, 5'd9, 1, 2'd2, 0, 0, 0, 32'h0);
      check($sformatf("wd_wait%0d_err", i), err_timeout, (i >= 4) ? 1 : 0);
    end
    cyc(1, 1, 0, 32'h4000, 32'h800, 5'd9, 1, 2'd2, 0, 0, 1, 32'h44445555);
    check("wd_done_valid", wb_valid, 1);
    check("wd_done_data", wb_data, 32'h44445555);
    check("wd_sticky", err_timeout, 1);
    do_reset();

    // Reset while waiting: later response is ignored.
    cyc(1, 1, 0, 32'h5000, 32'h900, 5'd2, 1, 2'd2, 0, 0, 0, 32'h0);
    check("rstwait_stall", stall_seen, 1);
    do_reset();
    cyc(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 2'd0, 0, 0, 0, 32'h0);
    check("rstwait_idle_stall", stall_seen, 0);
    cyc(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 2'd0, 0, 0, 1, 32'h66666666);
    check("rstwait_ignored", wb_valid, 0);

    // Randomized traffic; instruction fields held while the model says stalled.
    hold = 0;
    r_v = 0; r_ld = 0; r_ex = 0; r_rw = 0; r_sg = 0; r_addr = 0; r_pc = 0; r_dst = 0; r_sz = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!hold) begin
        r_v    = ($urandom_range(0, 99) < 75);
        r_ld   = ($urandom_range(0, 99) < 60);
        r_ex   = ($urandom_range(0, 99) < 10);
        r_rw   = $urandom_range(0, 1);
        r_sg   = $urandom_range(0, 1);
        r_sz   = 2'($urandom_range(0, 3));
        r_addr = $urandom;
        r_pc   = $urandom;
        r_dst  = 5'($urandom_range(0, 31));
      end
      cyc(r_v, r_ld, r_ex, r_addr, r_pc, r_dst, r_rw, r_sz, r_sg,
          ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 35), $urandom);
      hold = m_stall;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
